// File: rtl/id_issue_ctrl.sv
// rtl/id_issue_ctrl.sv - decode-stage issue controller and register write scoreboard
// Per-register in-flight write counters gate issue on RAW and counter-saturation (WAW) hazards.
module id_issue_ctrl #(
  parameter int REG_ADDR_WIDTH = 5,
  parameter int NUM_REGS       = 32,
  parameter int CNT_WIDTH      = 2,
  parameter int STAT_WIDTH     = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      id_valid,
  input  logic [REG_ADDR_WIDTH-1:0] id_rs1,
  input  logic [REG_ADDR_WIDTH-1:0] id_rs2,
  input  logic                      id_rs2_used,
  input  logic [REG_ADDR_WIDTH-1:0] id_rd,
  input  logic                      id_wr_en,
  input  logic                      ex_ready,
  input  logic                      flush,
  input  logic                      wb_valid,
  input  logic [REG_ADDR_WIDTH-1:0] wb_rd,
  output logic                      issue,
  output logic                      stall_if,
  output logic                      busy,
  output logic                      sb_error,
  output logic [STAT_WIDTH-1:0]     stall_cycles
);

  localparam logic [CNT_WIDTH-1:0]  CNT_MAX  = '1;
  localparam logic [CNT_WIDTH-1:0]  CNT_ONE  = CNT_WIDTH'(1);
  localparam logic [STAT_WIDTH-1:0] STAT_ONE = STAT_WIDTH'(1);

  logic [CNT_WIDTH-1:0] cnt [NUM_REGS];
  logic [NUM_REGS-1:0]  wb_hit;
  logic [NUM_REGS-1:0]  inc;
  logic [NUM_REGS-1:0]  nonzero;
  logic                 rs1_ready;
  logic                 rs2_ready;
  logic                 raw;
  logic                 waw_full;
  logic                 err_now;

  // Entry 0 never matches, so x0 is never counted, decremented or flagged.
  always_comb begin
    wb_hit  = '0;
    nonzero = '0;
    for (int r = 1; r < NUM_REGS; r++) begin
      wb_hit[r]  = wb_valid && (wb_rd == REG_ADDR_WIDTH'(r));
      nonzero[r] = (cnt[r] != '0);
    end
  end

  // Write-through register file: a last pending write retiring now satisfies the read.
  always_comb begin
    rs1_ready = (id_rs1 == '0) || (cnt[id_rs1] == '0) ||
                ((cnt[id_rs1] == CNT_ONE) && wb_hit[id_rs1]);
    rs2_ready = (id_rs2 == '0) || (cnt[id_rs2] == '0) ||
                ((cnt[id_rs2] == CNT_ONE) && wb_hit[id_rs2]);
    raw       = !rs1_ready || (id_rs2_used && !rs2_ready);
    waw_full  = id_wr_en && (id_rd != '0) && (cnt[id_rd] == CNT_MAX) && !wb_hit[id_rd];
  end

  assign issue    = !rst && id_valid && !flush && ex_ready && !raw && !waw_full;
  assign stall_if = !rst && id_valid && !flush && !issue;
  assign busy     = |nonzero;

  always_comb begin
    inc     = '0;
    err_now = 1'b0;
    for (int r = 1; r < NUM_REGS; r++) begin
      inc[r] = issue && id_wr_en && (id_rd == REG_ADDR_WIDTH'(r));
      if (wb_hit[r] && !inc[r] && (cnt[r] == '0)) begin
        err_now = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < NUM_REGS; r++) begin
        cnt[r] <= '0;
      end
      sb_error     <= 1'b0;
      stall_cycles <= '0;
    end else begin
      for (int r = 0; r < NUM_REGS; r++) begin
        if (inc[r] && !wb_hit[r]) begin
          cnt[r] <= cnt[r] + CNT_ONE;
        end else if (wb_hit[r] && !inc[r] && (cnt[r] != '0)) begin
          cnt[r] <= cnt[r] - CNT_ONE;
        end
      end
      if (err_now) begin
        sb_error <= 1'b1;
      end
      if (stall_if && (stall_cycles != '1)) begin
        stall_cycles <= stall_cycles + STAT_ONE;
      end
    end
  end

endmodule

// File: tb/tb_id_issue_ctrl.sv
// tb/tb_id_issue_ctrl.sv - self-checking bench for id_issue_ctrl
// Directed scenarios plus randomized traffic against a pending-write reference model.
module tb_id_issue_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        id_valid;
  logic [4:0]  id_rs1;
  logic [4:0]  id_rs2;
  logic        id_rs2_used;
  logic [4:0]  id_rd;
  logic        id_wr_en;
  logic        ex_ready;
  logic        flush;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic        issue;
  logic        stall_if;
  logic        busy;
  logic        sb_error;
  logic [31:0] stall_cycles;

  int checks = 0;
  int errors = 0;

  // Reference model: number of writes still pending per register.
  int          mc [32];
  bit          m_err;
  logic [31:0] m_stall;

  always #5 clk = ~clk;

  id_issue_ctrl dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rs2_used(id_rs2_used), .id_rd(id_rd), .id_wr_en(id_wr_en), .ex_ready(ex_ready),
    .flush(flush), .wb_valid(wb_valid), .wb_rd(wb_rd), .issue(issue), .stall_if(stall_if),
    .busy(busy), .sb_error(sb_error), .stall_cycles(stall_cycles)
  );

  function automatic bit m_hit(int r);
    return wb_valid && (r != 0) && (int'(wb_rd) == r);
  endfunction

  function automatic bit m_ready(int r);
    return (r == 0) || (mc[r] == 0) || (mc[r] == 1 && m_hit(r));
  endfunction

  function automatic bit m_issue();
    if (rst || !id_valid || flush || !ex_ready) return 1'b0;
    if (!m_ready(int'(id_rs1))) return 1'b0;
    if (id_rs2_used && !m_ready(int'(id_rs2))) return 1'b0;
    if (id_wr_en && id_rd != 0 && mc[id_rd] == 3 && !m_hit(int'(id_rd))) return 1'b0;
    return 1'b1;
  endfunction

  function automatic bit m_stall_now();
    return !rst && id_valid && !flush && !m_issue();
  endfunction

  function automatic bit m_busy();
    for (int r = 1; r < 32; r++) if (mc[r] != 0) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_step();
    bit is, st, inc, dec;
    is = m_issue();
    st = m_stall_now();
    if (rst) begin
      for (int r = 0; r < 32; r++) mc[r] = 0;
      m_err   = 1'b0;
      m_stall = 32'd0;
    end else begin
      for (int r = 1; r < 32; r++) begin
        inc = is && id_wr_en && (int'(id_rd) == r);
        dec = m_hit(r);
        if (inc && !dec) mc[r] = mc[r] + 1;
        else if (dec && !inc) begin
          if (mc[r] > 0) mc[r] = mc[r] - 1;
          else m_err = 1'b1;
        end
      end
      if (st && m_stall != 32'hFFFF_FFFF) m_stall = m_stall + 32'd1;
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #2;
  endtask

  task automatic set_idle();
    id_valid = 0; id_rs1 = 0; id_rs2 = 0; id_rs2_used = 0; id_rd = 0; id_wr_en = 0;
    ex_ready = 1; flush = 0; wb_valid = 0; wb_rd = 0;
  endtask

  task automatic set_id(input logic [4:0] rs1, input logic [4:0] rs2, input logic used,
                        input logic [4:0] rd, input logic wr);
    id_valid = 1; id_rs1 = rs1; id_rs2 = rs2; id_rs2_used = used; id_rd = rd; id_wr_en = wr;
  endtask

  task automatic test_reset();
    rst = 1; set_idle();
    tick(); tick();
    rst = 0;
    tick(); tick();
    #1;
    checks++; if (issue !== 1'b0) begin errors++; $display("FAIL reset_issue act=%b exp=0", issue); end
    checks++; if (stall_if !== 1'b0) begin errors++; $display("FAIL reset_stall_if act=%b exp=0", stall_if); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy act=%b exp=0", busy); end
    checks++; if (sb_error !== 1'b0) begin errors++; $display("FAIL reset_sb_error act=%b exp=0", sb_error); end
    checks++; if (stall_cycles !== 32'd0) begin errors++; $display("FAIL reset_stall_cycles act=%0d exp=0", stall_cycles); end
  endtask

  task automatic test_raw();
    set_idle(); set_id(5'd1, 5'd2, 1'b1, 5'd5, 1'b1); #1;
    checks++; if (issue !== 1'b1) begin errors++; $display("FAIL raw_first_issue act=%b exp=1", issue); end
    tick();
    set_id(5'd5, 5'd0, 1'b0, 5'd6, 1'b0); #1;
    checks++; if (issue !== 1'b0) begin errors++; $display("FAIL raw_stall_issue act=%b exp=0", issue); end
    checks++; if (stall_if !== 1'b1) begin errors++; $display("FAIL raw_stall_if act=%b exp=1", stall_if); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL raw_busy act=%b exp=1", busy); end
    tick();
    wb_valid = 1; wb_rd = 5'd5; #1;
    checks++; if (issue !== 1'b1) begin errors++; $display("FAIL raw_bypass_issue act=%b exp=1", issue); end
    tick();
    set_idle(); #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL raw_drained_busy act=%b exp=0", busy); end
    checks++; if (stall_cycles !== 32'd1) begin errors++; $display("FAIL raw_stall_cycles act=%0d exp=1", stall_cycles); end
  endtask

  task automatic test_waw();
    set_idle();
    for (int i = 0; i < 3; i++) begin
      set_id(5'd0, 5'd0, 1'b0, 5'd7, 1'b1); #1;
      checks++; if (issue !== 1'b1) begin errors++; $display("FAIL waw_fill%0d_issue act=%b exp=1", i, issue); end
      tick();
    end
    #1;
    checks++; if (issue !== 1'b0) begin errors++; $display("FAIL waw_full_issue act=%b exp=0", issue); end
    checks++; if (stall_if !== 1'b1) begin errors++; $display("FAIL waw_full_stall act=%b exp=1", stall_if); end
    wb_valid = 1; wb_rd = 5'd7; #1;
    checks++; if (issue !== 1'b1) begin errors++; $display("FAIL waw_wb_issue act=%b exp=1", issue); end
    tick();
    set_idle(); wb_valid = 1; wb_rd = 5'd7;
    tick(); tick();
    #1;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL waw_one_left_busy act=%b exp=1", busy); end
    tick();
    set_idle(); #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL waw_drained_busy act=%b exp=0", busy); end
    checks++; if (sb_error !== 1'b0) begin errors++; $display("FAIL waw_sb_error act=%b exp=0", sb_error); end
  endtask

  task automatic test_imm_x0();
    set_idle(); set_id(5'd0, 5'd0, 1'b0, 5'd5, 1'b1);
    tick();
    set_id(5'd1, 5'd5, 1'b1, 5'd0, 1'b0); #1;
    checks++; if (issue !== 1'b0) begin errors++; $display("FAIL imm_rs2_used_issue act=%b exp=0", issue); end
    set_id(5'd1, 5'd5, 1'b0, 5'd0, 1'b1); #1;
    checks++; if (issue !== 1'b1) begin errors++; $display("FAIL imm_rs2_unused_issue act=%b exp=1", issue); end
    tick();
    set_id(5'd0, 5'd0, 1'b1, 5'd0, 1'b0); #1;
    checks++; if (issue !== 1'b1) begin errors++; $display("FAIL x0_src_issue act=%b exp=1", issue); end
    tick();
    set_idle(); wb_valid = 1; wb_rd = 5'd5;
    tick();
    set_idle(); wb_valid = 1; wb_rd = 5'd0;
    tick();
    set_idle(); #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL x0_write_busy act=%b exp=0", busy); end
    checks++; if (sb_error !== 1'b0) begin errors++; $display("FAIL x0_wb_sb_error act=%b exp=0", sb_error); end
  endtask

  task automatic test_flush();
    logic [31:0] s0;
    set_idle(); set_id(5'd0, 5'd0, 1'b0, 5'd3, 1'b1);
    tick();
    s0 = m_stall;
    set_id(5'd0, 5'd0, 1'b0, 5'd0, 1'b0); ex_ready = 0;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (stall_if !== 1'b1) begin errors++; $display("FAIL bp%0d_stall_if act=%b exp=1", i, stall_if); end
      tick();
    end
    #1;
    checks++; if (stall_cycles !== s0 + 32'd3) begin errors++; $display("FAIL bp_stall_cycles act=%0d exp=%0d", stall_cycles, s0 + 32'd3); end
    set_id(5'd0, 5'd0, 1'b0, 5'd3, 1'b1); ex_ready = 1; flush = 1; #1;
    checks++; if (issue !== 1'b0) begin errors++; $display("FAIL flush_issue act=%b exp=0", issue); end
    checks++; if (stall_if !== 1'b0) begin errors++; $display("FAIL flush_stall_if act=%b exp=0", stall_if); end
    tick(); tick();
    #1;
    checks++; if (stall_cycles !== s0 + 32'd3) begin errors++; $display("FAIL flush_stall_frozen act=%0d exp=%0d", stall_cycles, s0 + 32'd3); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL flush_keeps_cnt act=%b exp=1", busy); end
    set_idle(); wb_valid = 1; wb_rd = 5'd3;
    tick();
    set_idle(); #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL flush_drain_busy act=%b exp=0", busy); end
    checks++; if (sb_error !== 1'b0) begin errors++; $display("FAIL flush_drain_err act=%b exp=0", sb_error); end
  endtask

  task automatic test_error_reset();
    set_idle(); wb_valid = 1; wb_rd = 5'd9;
    tick();
    set_idle(); #1;
    checks++; if (sb_error !== 1'b1) begin errors++; $display("FAIL err_set act=%b exp=1", sb_error); end
    set_id(5'd0, 5'd0, 1'b0, 5'd4, 1'b1);
    tick();
    set_id(5'd0, 5'd0, 1'b0, 5'd10, 1'b1);
    tick();
    set_idle(); #1;
    checks++; if (sb_error !== 1'b1) begin errors++; $display("FAIL err_held act=%b exp=1", sb_error); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL err_busy act=%b exp=1", busy); end
    rst = 1; set_id(5'd0, 5'd0, 1'b0, 5'd4, 1'b1); #1;
    checks++; if (issue !== 1'b0) begin errors++; $display("FAIL rst_issue act=%b exp=0", issue); end
    checks++; if (stall_if !== 1'b0) begin errors++; $display("FAIL rst_stall_if act=%b exp=0", stall_if); end
    tick();
    rst = 0; set_idle(); #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy act=%b exp=0", busy); end
    checks++; if (sb_error !== 1'b0) begin errors++; $display("FAIL rst_sb_error act=%b exp=0", sb_error); end
    checks++; if (stall_cycles !== 32'd0) begin errors++; $display("FAIL rst_stall_cycles act=%0d exp=0", stall_cycles); end
  endtask

  task automatic test_random();
    for (int n = 0; n < 600; n++) begin
      rst         = ($urandom_range(0, 63) == 0);
      id_valid    = ($urandom_range(0, 3) != 0);
      id_rs1      = 5'($urandom_range(0, 7));
      id_rs2      = 5'($urandom_range(0, 7));
      id_rs2_used = $urandom_range(0, 1) != 0;
      id_rd       = 5'($urandom_range(0, 7));
      id_wr_en    = ($urandom_range(0, 3) != 0);
      ex_ready    = ($urandom_range(0, 3) != 0);
      flush       = ($urandom_range(0, 7) == 0);
      wb_valid    = $urandom_range(0, 1) != 0;
      wb_rd       = 5'($urandom_range(0, 7));
      #1;
      checks++; if (issue !== m_issue()) begin errors++; $display("FAIL rnd%0d_issue act=%b exp=%b", n, issue, m_issue()); end
      checks++; if (stall_if !== m_stall_now()) begin errors++; $display("FAIL rnd%0d_stall_if act=%b exp=%b", n, stall_if, m_stall_now()); end
      checks++; if (busy !== m_busy()) begin errors++; $display("FAIL rnd%0d_busy act=%b exp=%b", n, busy, m_busy()); end
      checks++; if (sb_error !== m_err) begin errors++; $display("FAIL rnd%0d_sb_error act=%b exp=%b", n, sb_error, m_err); end
      checks++; if (stall_cycles !== m_stall) begin errors++; $display("FAIL rnd%0d_stall_cycles act=%0d exp=%0d", n, stall_cycles, m_stall); end
      tick();
    end
    rst = 0; set_idle();
  endtask

  initial begin
    for (int r = 0; r < 32; r++) mc[r] = 0;
    m_err = 1'b0;
    m_stall = 32'd0;
    rst = 1; set_idle();
    #2;
    test_reset();
    test_raw();
    test_waw();
    test_imm_x0();
    test_flush();
    test_error_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
